// File: rtl/fetch_pkg.sv
// Purpose : shared types and constants for the instruction fetch controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package fetch_pkg;

   // Fetch controller FSM states.
   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam int unsigned PC_STEP          = 4;
   localparam int unsigned DBG_STARVE_LIMIT = 4;
   localparam int unsigned QUEUE_DEPTH      = 2;
   localparam int unsigned STARVE_CNT_W     = $clog2(DBG_STARVE_LIMIT + 1);

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'(PC_STEP);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Purpose : 2-entry prefetch FIFO of {pc, inst} words with push, pop, flush and count.
// Latency : a pushed word is visible at the head the cycle after the push edge.
// Backpr. : push is dropped when full unless a pop happens in the same cycle.
//
// Ports: push/push_dat write an entry, pop removes the head, flush empties the
// queue (wins over push/pop); head_vld/head_dat present the oldest entry
// (head_dat is zero when empty); count is the current occupancy.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic             head_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] ent0;   // head
   logic [WIDTH-1:0] ent1;   // second entry
   logic [1:0]       cnt;
   logic             do_pop;
   logic             do_push;

   // Guard against caller misuse: never pop empty, never overfill.
   assign do_pop  = pop & (cnt != 2'd0);
   assign do_push = push & ((cnt < 2'(QUEUE_DEPTH)) | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= push_dat;
               else             ent1 <= push_dat;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new word lands behind the survivor.
               if (cnt == 2'd1) begin
                  ent0 <= push_dat;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_vld = (cnt != 2'd0);
   assign head_dat = head_vld ? ent0 : '0;
   assign count    = cnt;

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Purpose : owns the fetch PC, drives the combinational imem read port and feeds IF/ID.
// Latency : fetched word valid the cycle after its fetch edge; redirect target valid after N+1.
// Backpr. : out_ready=0 lets the 2-entry queue fill, then fetch stalls and fetch_pc holds.
//
// Ports: clk/rst_n (async active-low); mem_addr/mem_data imem read port;
// redirect_valid/redirect_pc from EX; halt/halt_pc from decode; go resumes;
// out_valid/out_ready/out_inst/out_pc toward IF/ID; halted status.
// Optional macro FETCH_DEBUG_PORT_EN adds dbg_req/dbg_addr/dbg_gnt/dbg_data,
// a debug reader that shares the memory port with starvation protection.
module ins_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  halt,
   input  logic [31:0]           halt_pc,
   input  logic                  go,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [31:0]           out_pc,
   output logic                  halted
`ifdef FETCH_DEBUG_PORT_EN
  ,input  logic                  dbg_req,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic                  dbg_gnt,
   output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

   localparam int unsigned Q_W = 32 + DATA_WIDTH;

   fetch_state_t          state;
   fetch_state_t          state_nxt;
   logic [31:0]           fetch_pc;
   logic [31:0]           fetch_pc_nxt;

   logic                  q_vld;
   logic [Q_W-1:0]        q_head;
   logic [1:0]            q_count;
   logic                  pop;
   logic                  flush;
   logic                  fetch_wanted;
   logic                  fetch;
   logic                  dbg_win;
   logic [ADDR_WIDTH-1:0] pc_word_addr;

   assign pc_word_addr = fetch_pc[ADDR_WIDTH+1:2];

   assign pop = out_valid & out_ready;

   // A fetch slot exists whenever nothing higher priority claims the cycle and
   // the queue has room (a same-cycle pop frees one).
   assign fetch_wanted = (state == RUN) & ~redirect_valid & ~halt &
                         ((q_count < 2'(QUEUE_DEPTH)) | pop);
   assign fetch        = fetch_wanted & ~dbg_win;

   assign flush = redirect_valid | (halt & (state == RUN));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      halted       = (state == HALTED);
      if (redirect_valid) begin
         state_nxt    = RUN;
         fetch_pc_nxt = redirect_pc;
      end else begin
         case (state)
            RUN: begin
               if (halt) begin
                  state_nxt    = HALTED;
                  fetch_pc_nxt = halt_pc;
               end else if (fetch) begin
                  fetch_pc_nxt = next_pc(fetch_pc);
               end
            end
            HALTED: begin
               if (go) state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // ---------------------------------------------------------------- queue
   fetch_queue #(
      .WIDTH (Q_W)
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fetch),
      .push_dat ({fetch_pc, mem_data}),
      .pop      (pop),
      .flush    (flush),
      .head_vld (q_vld),
      .head_dat (q_head),
      .count    (q_count)
   );

   assign out_valid = q_vld & (state == RUN);
   assign out_pc    = q_head[Q_W-1:DATA_WIDTH];
   assign out_inst  = q_head[DATA_WIDTH-1:0];

   // ---------------------------------------------------------------- debug port
`ifdef FETCH_DEBUG_PORT_EN
   logic [STARVE_CNT_W-1:0] starve_cnt;

   // After DBG_STARVE_LIMIT consecutive ungranted cycles the debug reader
   // takes the port for one cycle regardless of fetch demand.
   assign dbg_win  = dbg_req & (starve_cnt >= STARVE_CNT_W'(DBG_STARVE_LIMIT));
   assign dbg_gnt  = dbg_req & (dbg_win | ~fetch_wanted);
   assign mem_addr = dbg_gnt ? dbg_addr : pc_word_addr;
   assign dbg_data = dbg_gnt ? mem_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!dbg_req || dbg_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt < STARVE_CNT_W'(DBG_STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign dbg_win  = 1'b0;
   assign mem_addr = pc_word_addr;
`endif

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Purpose : self-checking bench for ins_fetch_ctrl against a queue-level reference model.
// Latency : n/a.
// Backpr. : exercises out_ready stalls, redirects, halt/go, wrap and async reset.
module tb_ins_fetch_ctrl;

   localparam int          DW  = 32;
   localparam int          AW  = 10;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          halt;
   logic [31:0]   halt_pc;
   logic          go;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_inst;
   logic [31:0]   out_pc;
   logic          halted;
`ifdef FETCH_DEBUG_PORT_EN
   logic          dbg_req;
   logic [AW-1:0] dbg_addr;
   logic          dbg_gnt;
   logic [DW-1:0] dbg_data;
`endif

   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign mem_data = mem[mem_addr];

   always #5 clk = ~clk;

   ins_fetch_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RESET_PC   (RPC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halt_pc        (halt_pc),
      .go             (go),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .halted         (halted)
`ifdef FETCH_DEBUG_PORT_EN
     ,.dbg_req        (dbg_req),
      .dbg_addr       (dbg_addr),
      .dbg_gnt        (dbg_gnt),
      .dbg_data       (dbg_data)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: the prefetch queue as a list of {pc, inst} words.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;
   bit          mhalt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mpc   = RPC;
      mhalt = 1'b0;
   endtask

   task automatic check_outputs();
      ent_t h;
      h = '0;
      if (mq.size() != 0) h = mq[0];
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_pc",    out_pc,         h.pc);
      chk("out_inst",  out_inst,       h.inst);
      chk("halted",    32'(halted),    32'(mhalt));
      chk("mem_addr",  32'(mem_addr),  32'(mpc[AW+1:2]));
`ifdef FETCH_DEBUG_PORT_EN
      chk("dbg_gnt_idle", 32'(dbg_gnt), 32'd0);
`endif
   endtask

   // Apply one clock edge's worth of the fetch rules to the model.
   task automatic model_step();
      int  sz;
      bit  popd;
      sz   = mq.size();
      popd = (sz != 0) && out_ready && !mhalt;
      if (redirect_valid) begin
         mq.delete();
         mpc   = redirect_pc;
         mhalt = 1'b0;
      end else if (halt && !mhalt) begin
         mq.delete();
         mpc   = halt_pc;
         mhalt = 1'b1;
      end else if (mhalt) begin
         if (go) mhalt = 1'b0;
      end else begin
         if (popd) void'(mq.pop_front());
         if (sz < 2 || popd) begin
            mq.push_back('{pc: mpc, inst: mem[mpc[AW+1:2]]});
            mpc = mpc + 32'd4;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cycle();
      redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      halt_pc        = '0;
      go             = 1'b0;
      out_ready      = 1'b0;
`ifdef FETCH_DEBUG_PORT_EN
      dbg_req        = 1'b0;
      dbg_addr       = '0;
`endif
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Streaming from reset: 0,4,8,12 back to back.
      out_ready = 1'b1;
      cycles(6);

      // Backpressure: queue fills, fetch_pc freezes, release without gaps.
      do_redirect(32'h0);
      out_ready = 1'b0;
      cycles(6);
      out_ready = 1'b1;
      cycles(4);

      // Redirect while full.
      out_ready = 1'b0;
      cycles(3);
      do_redirect(32'h40);
      out_ready = 1'b1;
      cycles(3);

      // Halt, idle, resume.
      halt    = 1'b1;
      halt_pc = 32'h20;
      cycle();
      halt = 1'b0;
      cycles(10);
      go = 1'b1;
      cycle();
      go = 1'b0;
      cycles(3);

      // Memory word-address wrap and 32-bit PC wrap.
      do_redirect(32'h0000_0FF8);
      cycles(5);
      do_redirect(32'hFFFF_FFF8);
      cycles(5);

      // Asynchronous reset mid-operation while halted with a stalled queue.
      out_ready = 1'b0;
      cycles(3);
      halt    = 1'b1;
      halt_pc = 32'h100;
      cycle();
      halt  = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_pc",    out_pc,         32'd0);
      chk("arst_halted",    32'(halted),    32'd0);
      chk("arst_mem_addr",  32'(mem_addr),  32'(RPC[AW+1:2]));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      cycles(3);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         out_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = $urandom;
         halt           = ($urandom_range(0, 24) == 0);
         halt_pc        = $urandom;
         go             = ($urandom_range(0, 3) == 0);
         cycle();
      end
      redirect_valid = 1'b0;
      halt           = 1'b0;
      go             = 1'b0;

`ifdef FETCH_DEBUG_PORT_EN
      // Starvation: continuous fetch, debug granted on its 5th pending cycle.
      out_ready = 1'b1;
      do_redirect(32'h0);
      cycles(3);
      dbg_req  = 1'b1;
      dbg_addr = AW'(5);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("dbg_gnt_starve", 32'(dbg_gnt), 32'(k == 5));
         if (k == 5) begin
            chk("dbg_data", dbg_data, mem[5]);
            chk("dbg_mem_addr", 32'(mem_addr), 32'd5);
         end
         @(posedge clk);
         #1;
      end
      dbg_req = 1'b0;
      // In HALTED the grant is immediate.
      halt    = 1'b1;
      halt_pc = 32'h0;
      @(posedge clk);
      #1 halt = 1'b0;
      dbg_req = 1'b1;
      @(negedge clk);
      chk("dbg_gnt_halted",  32'(dbg_gnt), 32'd1);
      chk("dbg_data_halted", dbg_data,     mem[5]);
      dbg_req = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
